// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - debounced switch-to-LED pattern driver; optional PWM dimming with LED_PWM_EN
module led_pattern_ctrl #(
    parameter int NUM_SW     = 4,
    parameter int NUM_LED    = 8,
    parameter int DEB_CYCLES = 16,
    parameter int TICK_DIV   = 25_000_000,
    parameter int PWM_BITS   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_SW-1:0]   s,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] duty,
    output logic [NUM_LED-1:0]  led
);

    localparam int DW    = $clog2(DEB_CYCLES + 1);
    localparam int PW    = $clog2(TICK_DIV);
    localparam int NPAIR = (NUM_SW < NUM_LED / 2) ? NUM_SW : NUM_LED / 2;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_t;

    logic [NUM_SW-1:0]  s_meta;
    logic [NUM_SW-1:0]  s_sync;
    logic [NUM_SW-1:0]  s_db;
    logic [DW-1:0]      deb_cnt [NUM_SW];
    logic [PW-1:0]      pre_cnt;
    logic               tick;
    mode_t              mode_q;
    logic               mode_chg;
    logic               phase;
    logic [NUM_LED-1:0] chase;
    logic [NUM_LED-1:0] count;
    logic [NUM_LED-1:0] pattern;
    logic [NUM_LED-1:0] mask;

    // Two-flop synchroniser for the raw switch pins
    always_ff @(posedge clk) begin
        if (reset) begin
            s_meta <= '0;
            s_sync <= '0;
        end else begin
            s_meta <= s;
            s_sync <= s_meta;
        end
    end

    // Per-bit debounce: a change is accepted only after DEB_CYCLES straight cycles of disagreement
    always_ff @(posedge clk) begin
        if (reset) begin
            s_db <= '0;
            for (int i = 0; i < NUM_SW; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SW; i++) begin
                if (s_sync[i] == s_db[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    s_db[i]    <= s_sync[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    assign tick     = (pre_cnt == TICK_LAST);
    assign mode_chg = (mode_t'(mode) != mode_q);

    // Free-running tick prescaler; deliberately untouched by mode changes
    always_ff @(posedge clk) begin
        if (reset) pre_cnt <= '0;
        else       pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
    end

    // Registered copy of the mode select, used to detect changes and pick the pattern
    always_ff @(posedge clk) begin
        if (reset) mode_q <= MODE_DIRECT;
        else       mode_q <= mode_t'(mode);
    end

    // Pattern state: a mode change restarts every pattern and wins over a coincident tick
    always_ff @(posedge clk) begin
        if (reset || mode_chg) begin
            phase <= 1'b0;
            chase <= NUM_LED'(1);
            count <= '0;
        end else if (tick) begin
            phase <= ~phase;
            chase <= {chase[NUM_LED-2:0], chase[NUM_LED-1]};
            count <= count + NUM_LED'(1);
        end
    end

    // Pattern select from the registered mode
    always_comb begin
        pattern = '0;
        case (mode_q)
            MODE_DIRECT: begin
                for (int i = 0; i < NPAIR; i++) begin
                    pattern[2*i]   = s_db[i];
                    pattern[2*i+1] = ~s_db[i];
                end
            end
            MODE_BLINK: pattern = {NUM_LED{phase}};
            MODE_CHASE: pattern = chase;
            default:    pattern = count;
        endcase
    end

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt;

    // Brightness counter; LEDs are lit while it is below duty
    always_ff @(posedge clk) begin
        if (reset) pwm_cnt <= '0;
        else       pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end

    assign mask = {NUM_LED{pwm_cnt < duty}};
`else
    logic unused_duty;
    assign unused_duty = ^duty;
    assign mask        = '1;
`endif

    // Single output register stage
    always_ff @(posedge clk) begin
        if (reset) led <= '0;
        else       led <= pattern & mask;
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - scoreboard bench for led_pattern_ctrl (optional LED_PWM_EN coverage)
module tb_led_pattern_ctrl;

    localparam int TICK_DIV = 5;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] s     = 4'hF;
    logic [1:0] mode  = 2'd2;
    logic [3:0] duty  = 4'd15;
    logic [7:0] led;

    int ntests = 0;
    int nfail  = 0;
    int tb_pre = 0;

    logic [1:0] m_mode_q;
    logic       m_phase;
    logic [7:0] m_chase;
    logic [7:0] m_count;
    logic [3:0] m_sdb;
`ifdef LED_PWM_EN
    logic [3:0] m_pwm;
`endif
    logic [7:0] exp_q [$];

    led_pattern_ctrl #(
        .NUM_SW(4), .NUM_LED(8), .DEB_CYCLES(4), .TICK_DIV(TICK_DIV), .PWM_BITS(4)
    ) dut (
        .clk(clk), .reset(reset), .s(s), .mode(mode), .duty(duty), .led(led)
    );

    always #5 clk = ~clk;

    // Expected prescaler position, used to know which edges carry a tick
    always @(posedge clk) begin
        if (reset) tb_pre <= 0;
        else       tb_pre <= (tb_pre == TICK_DIV - 1) ? 0 : tb_pre + 1;
    end

    function automatic logic [7:0] pat();
        logic [7:0] p;
        p = 8'h00;
        case (m_mode_q)
            2'd0: for (int i = 0; i < 4; i++) begin
                p[2*i]   = m_sdb[i];
                p[2*i+1] = ~m_sdb[i];
            end
            2'd1: p = {8{m_phase}};
            2'd2: p = m_chase;
            default: p = m_count;
        endcase
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cyc();
        reset    = 1'b1;
        m_mode_q = 2'd0;
        m_phase  = 1'b0;
        m_chase  = 8'h01;
        m_count  = 8'h00;
        m_sdb    = 4'h0;
`ifdef LED_PWM_EN
        m_pwm    = 4'h0;
`endif
        exp_q.push_back(8'h00);
        step();
    endtask

    task automatic cyc();
        logic       tick;
        logic [7:0] e;
        tick = (tb_pre == TICK_DIV - 1);
        e    = pat();
`ifdef LED_PWM_EN
        if (!(m_pwm < duty)) e = 8'h00;
        m_pwm = m_pwm + 4'd1;
`endif
        if (mode != m_mode_q) begin
            m_phase = 1'b0;
            m_chase = 8'h01;
            m_count = 8'h00;
        end else if (tick) begin
            m_phase = ~m_phase;
            m_chase = {m_chase[6:0], m_chase[7]};
            m_count = m_count + 8'd1;
        end
        m_mode_q = mode;
        exp_q.push_back(e);
        step();
    endtask

    task automatic test_reset();
        logic [7:0] e;
        s    = 4'hF;
        mode = 2'd2;
        for (int k = 0; k < 3; k++) begin
            rst_cyc();
            e = exp_q.pop_front();
            ntests++;
            if (led !== e) begin nfail++; $display("FAIL reset[%0d]: led=%h expected %h", k, led, e); end
        end
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            e = exp_q.pop_front();
            ntests++;
            if (led !== e) begin nfail++; $display("FAIL release[%0d]: led=%h expected %h", k, led, e); end
        end
        m_sdb = 4'hF;
    endtask

    task automatic test_direct();
        logic [7:0] e;
        mode = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            e = exp_q.pop_front();
            ntests++;
            if (led !== e) begin nfail++; $display("FAIL direct_entry[%0d]: led=%h expected %h", k, led, e); end
        end
        s = 4'h5;
        for (int k = 0; k < 10; k++) begin
            if (k == 6) m_sdb = 4'h5;
            cyc();
            e = exp_q.pop_front();
            ntests++;
            if (led !== e) begin nfail++; $display("FAIL direct_latency[%0d]: led=%h expected %h", k, led, e); end
        end
        s = 4'h4;
        for (int k = 0; k < 12; k++) begin
            if (k == 2) s = 4'h5;
            cyc();
            e = exp_q.pop_front();
            ntests++;
            if (led !== e || led !== 8'h99) begin
                nfail++; $display("FAIL direct_glitch[%0d]: led=%h expected %h", k, led, e);
            end
        end
    endtask

    task automatic test_chase();
        logic [7:0] e;
        logic [7:0] prev;
        logic       saw_wrap;
        saw_wrap = 1'b0;
        prev     = 8'h00;
        mode     = 2'd2;
        for (int k = 0; k < 100; k++) begin
            cyc();
            e = exp_q.pop_front();
            ntests++;
            if (led !== e) begin nfail++; $display("FAIL chase[%0d]: led=%h expected %h", k, led, e); end
            if (prev == 8'h80 && led == 8'h01) saw_wrap = 1'b1;
            prev = led;
        end
        ntests++;
        if (saw_wrap !== 1'b1) begin nfail++; $display("FAIL chase_wrap: seen=%b expected 1", saw_wrap); end
    endtask

    task automatic test_count();
        logic [7:0] e;
        logic [7:0] prev;
        logic       saw_wrap;
        saw_wrap = 1'b0;
        prev     = 8'h00;
        mode     = 2'd3;
        for (int k = 0; k < 1300; k++) begin
            cyc();
            e = exp_q.pop_front();
            ntests++;
            if (led !== e) begin nfail++; $display("FAIL count[%0d]: led=%h expected %h", k, led, e); end
            if (prev == 8'hFF && led == 8'h00) saw_wrap = 1'b1;
            prev = led;
        end
        ntests++;
        if (saw_wrap !== 1'b1) begin nfail++; $display("FAIL count_wrap: seen=%b expected 1", saw_wrap); end
        for (int k = 0; k < TICK_DIV && tb_pre != TICK_DIV - 1; k++) begin
            cyc();
            e = exp_q.pop_front();
            ntests++;
            if (led !== e) begin nfail++; $display("FAIL count_align[%0d]: led=%h expected %h", k, led, e); end
        end
        ntests++;
        if (tb_pre != TICK_DIV - 1) begin nfail++; $display("FAIL tick_align: pre=%0d expected %0d", tb_pre, TICK_DIV - 1); end
        mode = 2'd2;
        for (int k = 0; k < 2; k++) begin
            cyc();
            e = exp_q.pop_front();
            ntests++;
            if (led !== e) begin nfail++; $display("FAIL count_to_chase[%0d]: led=%h expected %h", k, led, e); end
        end
        ntests++;
        if (led !== 8'h01) begin nfail++; $display("FAIL chase_restart: led=%h expected 01", led); end
    endtask

    task automatic test_blink();
        logic [7:0] e;
        mode = 2'd1;
        for (int k = 0; k < 30; k++) begin
            cyc();
            e = exp_q.pop_front();
            ntests++;
            if (led !== e) begin nfail++; $display("FAIL blink[%0d]: led=%h expected %h", k, led, e); end
        end
        for (int k = 0; k < 2 * TICK_DIV && !(m_phase == 1'b1 && led == 8'hFF); k++) begin
            cyc();
            e = exp_q.pop_front();
            ntests++;
            if (led !== e) begin nfail++; $display("FAIL blink_wait[%0d]: led=%h expected %h", k, led, e); end
        end
        ntests++;
        if (led !== 8'hFF) begin nfail++; $display("FAIL blink_high: led=%h expected ff", led); end
        rst_cyc();
        e = exp_q.pop_front();
        ntests++;
        if (led !== e || led !== 8'h00) begin nfail++; $display("FAIL blink_reset: led=%h expected 00", led); end
        reset = 1'b0;
        for (int k = 0; k < 25; k++) begin
            cyc();
            e = exp_q.pop_front();
            ntests++;
            if (led !== e) begin nfail++; $display("FAIL blink_restart[%0d]: led=%h expected %h", k, led, e); end
        end
        m_sdb = s;
    endtask

`ifdef LED_PWM_EN
    task automatic test_pwm();
        logic [7:0] e;
        mode = 2'd1;
        duty = 4'd0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            e = exp_q.pop_front();
            ntests++;
            if (led !== 8'h00 || led !== e) begin nfail++; $display("FAIL pwm_off[%0d]: led=%h expected 00", k, led); end
        end
        duty = 4'd4;
        for (int k = 0; k < 48; k++) begin
            cyc();
            e = exp_q.pop_front();
            ntests++;
            if (led !== e) begin nfail++; $display("FAIL pwm_duty[%0d]: led=%h expected %h", k, led, e); end
        end
        duty = 4'd15;
    endtask
`endif

    initial begin
        test_reset();
        test_direct();
        test_chase();
        test_count();
        test_blink();
`ifdef LED_PWM_EN
        test_pwm();
`endif
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
